jpeg_ycbcr_buf: RTL and testbench

JPEG_YCBCR_BUF -- requirements
Module: jpeg_ycbcr_buf

---
 rtl/jpeg_pkg.sv | 89 ++++++++
 rtl/jpeg_ycbcr_bank.sv | 62 ++++++
 rtl/jpeg_ycbcr_buf.sv | 199 +++++++++++++++++++
 tb/tb_jpeg_ycbcr_buf.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared encodings and per-mode MCU geometry for the YCbCr MCU buffer.
// Pixel coordinates are packed as {y[3:0], x[3:0]} inside one byte.
package jpeg_pkg;

    typedef enum logic [1:0] {
        MODE_444  = 2'd0,
        MODE_422  = 2'd1,
        MODE_420  = 2'd2,
        MODE_420X = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        COL_Y0 = 3'd0,
        COL_Y1 = 3'd1,
        COL_Y2 = 3'd2,
        COL_Y3 = 3'd3,
        COL_CB = 3'd4,
        COL_CR = 3'd5
    } color_e;

    localparam logic [2:0] NY_444 = 3'd1;
    localparam logic [2:0] NY_422 = 3'd2;
    localparam logic [2:0] NY_420 = 3'd4;

    localparam logic [8:0] FILL_444 = 9'd192;
    localparam logic [8:0] FILL_422 = 9'd256;
    localparam logic [8:0] FILL_420 = 9'd384;

    localparam logic [7:0] LAST_444 = 8'd63;
    localparam logic [7:0] LAST_422 = 8'd127;
    localparam logic [7:0] LAST_420 = 8'd255;

    function automatic logic [2:0] ny_of(input logic [1:0] m);
        logic [2:0] r;
        case (m)
            MODE_444: r = NY_444;
            MODE_422: r = NY_422;
            default:  r = NY_420;
        endcase
        return r;
    endfunction

    function automatic logic [8:0] fill_of(input logic [1:0] m);
        logic [8:0] r;
        case (m)
            MODE_444: r = FILL_444;
            MODE_422: r = FILL_422;
            default:  r = FILL_420;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] last_of(input logic [1:0] m);
        logic [7:0] r;
        case (m)
            MODE_444: r = LAST_444;
            MODE_422: r = LAST_422;
            default:  r = LAST_420;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] pix_xy(input logic [1:0] m,
                                          input logic [7:0] p);
        logic [7:0] r;
        case (m)
            MODE_444: r = {2'b00, p[5:3], 1'b0, p[2:0]};
            MODE_422: r = {1'b0, p[6:4], p[3:0]};
            default:  r = p;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] y_addr(input logic [7:0] xy);
        return {xy[7], xy[3], xy[6:4], xy[2:0]};
    endfunction

    function automatic logic [5:0] c_addr(input logic [1:0] m,
                                          input logic [7:0] xy);
        logic [5:0] r;
        case (m)
            MODE_444: r = {xy[6:4], xy[2:0]};
            MODE_422: r = {xy[6:4], xy[3:1]};
            default:  r = {xy[7:5], xy[3:1]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jpeg_ycbcr_bank.sv
// One MCU bank: Y/Cb/Cr sample arrays with a write port and a
// synchronous read port whose outputs hold while i_re is low.
module jpeg_ycbcr_bank
    import jpeg_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [2:0]    i_color,
    input  logic [5:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [7:0]    i_yaddr,
    input  logic [5:0]    i_caddr,
    output logic [DW-1:0] o_y,
    output logic [DW-1:0] o_cb,
    output logic [DW-1:0] o_cr
);

    logic [DW-1:0] r_ymem  [256];
    logic [DW-1:0] r_cbmem [64];
    logic [DW-1:0] r_crmem [64];
    logic [DW-1:0] r_y;
    logic [DW-1:0] r_cb;
    logic [DW-1:0] r_cr;

    // Luma array: Y block id selects the 64-entry quarter.
    always_ff @(posedge clk) begin
        if (i_we && !i_color[2]) begin
            r_ymem[{i_color[1:0], i_waddr}] <= i_wdata;
        end
        if (i_re) begin
            r_y <= r_ymem[i_yaddr];
        end
    end

    // Cb array.
    always_ff @(posedge clk) begin
        if (i_we && i_color == COL_CB) begin
            r_cbmem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_cb <= r_cbmem[i_caddr];
        end
    end

    // Cr array.
    always_ff @(posedge clk) begin
        if (i_we && i_color == COL_CR) begin
            r_crmem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_cr <= r_crmem[i_caddr];
        end
    end

    assign o_y  = r_y;
    assign o_cb = r_cb;
    assign o_cr = r_cr;

endmodule

// File: rtl/jpeg_ycbcr_buf.sv
// Ping-pong MCU buffer: block-ordered sample writes in, raster-order
// YCbCr pixels out through a read stage plus one output register.
module jpeg_ycbcr_buf
    import jpeg_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [2:0]    wr_color,
    input  logic [5:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_y,
    output logic [DW-1:0] rd_cb,
    output logic [DW-1:0] rd_cr,
    output logic          rd_first,
    output logic          rd_last,
    output logic          err
);

    logic [1:0] r_full;
    logic [1:0] r_lat;
    logic [8:0] r_cnt   [2];
    logic [1:0] r_bmode [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [7:0] r_pix;
    logic       r_s1v;
    logic       r_s1_bank;
    logic       r_s1_first;
    logic       r_s1_last;
    logic       r_ov;
    logic       r_obank;
    logic       r_first;
    logic       r_last;
    logic       r_err;
    logic [DW-1:0] r_y;
    logic [DW-1:0] r_cb;
    logic [DW-1:0] r_cr;

    logic          w_wacc;
    logic [1:0]    w_wmode;
    logic [2:0]    w_ny;
    logic          w_legal;
    logic          w_wr_en;
    logic [8:0]    w_cnt_nx;
    logic          w_fill;
    logic [1:0]    w_rmode;
    logic          w_out_en;
    logic          w_issue;
    logic          w_plast;
    logic          w_rel;
    logic [7:0]    w_xy;
    logic [7:0]    w_yaddr;
    logic [5:0]    w_caddr;
    logic [DW-1:0] w_y  [2];
    logic [DW-1:0] w_cb [2];
    logic [DW-1:0] w_cr [2];

    // Write side: a bank's mode is fixed by its first accepted sample.
    assign w_wacc   = wr_valid && !r_full[r_wptr];
    assign w_wmode  = r_lat[r_wptr] ? r_bmode[r_wptr] : mode;
    assign w_ny     = ny_of(w_wmode);
    assign w_legal  = (wr_color < COL_CB)
                    ? ({1'b0, wr_color[1:0]} < w_ny)
                    : (wr_color <= COL_CR);
    assign w_wr_en  = w_wacc && w_legal;
    assign w_cnt_nx = r_cnt[r_wptr] + 9'd1;
    assign w_fill   = w_wr_en && (w_cnt_nx == fill_of(w_wmode));

    // Read side: issue stage feeds memory, output register feeds port.
    assign w_rmode  = r_bmode[r_rptr];
    assign w_out_en = !r_ov || rd_ready;
    assign w_issue  = r_full[r_rptr] && (!r_s1v || w_out_en);
    assign w_plast  = (r_pix == last_of(w_rmode));
    assign w_rel    = r_ov && rd_ready && r_last;
    assign w_xy     = pix_xy(w_rmode, r_pix);
    assign w_yaddr  = y_addr(w_xy);
    assign w_caddr  = c_addr(w_rmode, w_xy);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        jpeg_ycbcr_bank #(
            .DW(DW)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_wr_en && (r_wptr == 1'(g))),
            .i_color (wr_color),
            .i_waddr (wr_addr),
            .i_wdata (wr_data),
            .i_re    (w_issue && (r_rptr == 1'(g))),
            .i_yaddr (w_yaddr),
            .i_caddr (w_caddr),
            .o_y     (w_y[g]),
            .o_cb    (w_cb[g]),
            .o_cr    (w_cr[g])
        );
    end

    // Bank fill/release bookkeeping and write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            r_lat  <= '0;
            r_wptr <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                r_cnt[b]   <= '0;
                r_bmode[b] <= MODE_444;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_rel && r_obank == 1'(b)) begin
                    r_full[b] <= 1'b0;
                    r_lat[b]  <= 1'b0;
                    r_cnt[b]  <= '0;
                end else if (w_wacc && r_wptr == 1'(b)) begin
                    r_lat[b] <= 1'b1;
                    if (!r_lat[b]) begin
                        r_bmode[b] <= mode;
                    end
                    if (w_wr_en) begin
                        r_cnt[b] <= w_cnt_nx;
                    end
                    if (w_fill) begin
                        r_full[b] <= 1'b1;
                    end
                end
            end
            if (w_fill) begin
                r_wptr <= ~r_wptr;
            end
        end
    end

    // Sticky flag for dropped illegal writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wacc && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    // Pixel sequencer and the two-deep read pipeline control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr     <= 1'b0;
            r_pix      <= '0;
            r_s1v      <= 1'b0;
            r_s1_bank  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_ov       <= 1'b0;
            r_obank    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pix      <= w_plast ? 8'd0 : r_pix + 8'd1;
                r_rptr     <= w_plast ? ~r_rptr : r_rptr;
                r_s1v      <= 1'b1;
                r_s1_bank  <= r_rptr;
                r_s1_first <= (r_pix == 8'd0);
                r_s1_last  <= w_plast;
            end else if (w_out_en) begin
                r_s1v <= 1'b0;
            end
            if (w_out_en) begin
                r_ov    <= r_s1v;
                r_obank <= r_s1_bank;
                r_first <= r_s1v && r_s1_first;
                r_last  <= r_s1v && r_s1_last;
            end
        end
    end

    // Output data register; content is meaningful only with rd_valid.
    always_ff @(posedge clk) begin
        if (w_out_en && r_s1v) begin
            r_y  <= w_y[r_s1_bank];
            r_cb <= w_cb[r_s1_bank];
            r_cr <= w_cr[r_s1_bank];
        end
    end

    assign wr_ready = !r_full[r_wptr];
    assign rd_valid = r_ov;
    assign rd_y     = r_y;
    assign rd_cb    = r_cb;
    assign rd_cr    = r_cr;
    assign rd_first = r_first;
    assign rd_last  = r_last;
    assign err      = r_err;

endmodule

// File: tb/tb_jpeg_ycbcr_buf.sv
// Self-checking bench for jpeg_ycbcr_buf: random MCU contents, raster
// pixel expectations computed from block geometry and subsampling.
module tb_jpeg_ycbcr_buf;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_color;
    logic [5:0] wr_addr;
    logic [8:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [8:0] rd_y;
    logic [8:0] rd_cb;
    logic [8:0] rd_cr;
    logic       rd_first;
    logic       rd_last;
    logic       err;

    int n_pass;
    int n_total;
    int stall_bad;
    logic wr_before;
    logic wr_after;

    logic [8:0] mY  [2][4][64];
    logic [8:0] mCb [2][64];
    logic [8:0] mCr [2][64];

    logic [8:0] cap_y  [256];
    logic [8:0] cap_cb [256];
    logic [8:0] cap_cr [256];
    logic       cap_f  [256];
    logic       cap_l  [256];

    jpeg_ycbcr_buf #(.DW(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_color (wr_color),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_y     (rd_y),
        .rd_cb    (rd_cb),
        .rd_cr    (rd_cr),
        .rd_first (rd_first),
        .rd_last  (rd_last),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_mcu(input int k);
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 4; b++) mY[k][b][a] = 9'($urandom);
            mCb[k][a] = 9'($urandom);
            mCr[k][a] = 9'($urandom);
        end
    endtask

    task automatic write_one(input logic [2:0] c, input logic [5:0] a,
                             input logic [8:0] d, output bit ok);
        wr_valid = 1'b1;
        wr_color = c;
        wr_addr  = a;
        wr_data  = d;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (wr_ready) begin
                tick;
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic write_mcu(input int m, input int k, input int lim,
                             output bit ok);
        int ny;
        int cnt;
        bit o;
        logic [2:0] c;
        logic [8:0] d;
        ny = (m == 0) ? 1 : (m == 1) ? 2 : 4;
        ok = 1'b1;
        cnt = 0;
        mode = 2'(m);
        for (int i = 0; i < ny + 2; i++) begin
            for (int a = 0; a < 64; a++) begin
                if (cnt < lim) begin
                    c = (i < ny) ? 3'(i) : (i == ny) ? 3'd4 : 3'd5;
                    d = (i < ny) ? mY[k][i][a]
                      : (i == ny) ? mCb[k][a] : mCr[k][a];
                    write_one(c, 6'(a), d, o);
                    ok &= o;
                    cnt++;
                    mode = 2'($urandom_range(3, 0));
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic drain(input int n, input bit rnd,
                         output int got, output int cyc);
        logic [8:0] py, pcb, pcr;
        logic pf, pl;
        bit stalled, seen, pend;
        got = 0;
        cyc = 0;
        stalled = 0;
        seen = 0;
        pend = 0;
        py = '0; pcb = '0; pcr = '0; pf = 0; pl = 0;
        while (got < n && cyc < 4000) begin
            rd_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (stalled && {rd_valid, rd_y, rd_cb, rd_cr, rd_first, rd_last}
                       !== {1'b1, py, pcb, pcr, pf, pl}) stall_bad++;
            if (rd_valid && rd_ready) begin
                cap_y[got]  = rd_y;
                cap_cb[got] = rd_cb;
                cap_cr[got] = rd_cr;
                cap_f[got]  = rd_first;
                cap_l[got]  = rd_last;
                got++;
                if (rd_last && !seen) begin
                    seen = 1;
                    pend = 1;
                    wr_before = wr_ready;
                end
            end
            stalled = rd_valid && !rd_ready;
            py = rd_y; pcb = rd_cb; pcr = rd_cr; pf = rd_first; pl = rd_last;
            tick;
            cyc++;
            if (pend) begin
                wr_after = wr_ready;
                pend = 0;
            end
        end
        rd_ready = 1'b0;
    endtask

    // Expected raster pixel for MCU k, mode m, from block geometry.
    function automatic int count_bad(input int m, input int k,
                                     input int off, input int n);
        int bad, w, hs, vs, x, y, ci;
        bad = 0;
        w  = (m == 0) ? 8 : 16;
        hs = (m == 0) ? 1 : 2;
        vs = (m == 2) ? 2 : 1;
        for (int p = 0; p < n; p++) begin
            x = p % w;
            y = p / w;
            ci = (y / vs) * 8 + x / hs;
            if (cap_y[off+p] !== mY[k][x/8 + 2*(y/8)][(y%8)*8 + x%8]) bad++;
            if (cap_cb[off+p] !== mCb[k][ci]) bad++;
            if (cap_cr[off+p] !== mCr[k][ci]) bad++;
            if (cap_f[off+p] !== (p == 0)) bad++;
            if (cap_l[off+p] !== (p == n - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %0b want 1", wr_ready); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else n_pass++;
        n_total++; if (rd_first !== 1'b0) $display("FAIL reset_rd_first: got %0b want 0", rd_first); else n_pass++;
        n_total++; if (rd_last !== 1'b0) $display("FAIL reset_rd_last: got %0b want 0", rd_last); else n_pass++;
    endtask

    task automatic test_ramp;
        bit ok;
        int got, cyc, bad;
        for (int a = 0; a < 64; a++) begin
            mY[0][0][a] = 9'(a);
            mCb[0][a] = 9'(a);
            mCr[0][a] = 9'(a);
        end
        write_mcu(0, 0, 192, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL ramp_write: got %0b want 1", ok); else n_pass++;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL ramp_lat0: got %0b want 0", rd_valid); else n_pass++;
        tick;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL ramp_lat1: got %0b want 0", rd_valid); else n_pass++;
        tick;
        n_total++; if (rd_valid !== 1'b1) $display("FAIL ramp_lat2: got %0b want 1", rd_valid); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL ramp_wr_ready: got %0b want 1", wr_ready); else n_pass++;
        drain(64, 0, got, cyc);
        n_total++; if (got !== 64) $display("FAIL ramp_count: got %0d want 64", got); else n_pass++;
        bad = count_bad(0, 0, 0, 64);
        n_total++; if (bad !== 0) $display("FAIL ramp_pixels: got %0d bad want 0", bad); else n_pass++;
        n_total++; if (cap_y[37] !== 9'd37) $display("FAIL ramp_px37: got %0d want 37", cap_y[37]); else n_pass++;
        n_total++; if (cap_l[63] !== 1'b1) $display("FAIL ramp_last63: got %0b want 1", cap_l[63]); else n_pass++;
    endtask

    task automatic test_chroma;
        bit ok;
        int got, cyc, bad, badc;
        rand_mcu(0);
        mCb[0][9] = 9'h55;
        write_mcu(2, 0, 384, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL chroma_write: got %0b want 1", ok); else n_pass++;
        drain(256, 0, got, cyc);
        n_total++; if (got !== 256) $display("FAIL chroma_count: got %0d want 256", got); else n_pass++;
        bad = count_bad(2, 0, 0, 256);
        n_total++; if (bad !== 0) $display("FAIL chroma_pixels: got %0d bad want 0", bad); else n_pass++;
        badc = 0;
        for (int y = 2; y < 4; y++)
            for (int x = 2; x < 4; x++)
                if (cap_cb[y*16 + x] !== 9'h55) badc++;
        n_total++; if (badc !== 0) $display("FAIL chroma_cb55: got %0d bad want 0", badc); else n_pass++;
        n_total++; if (cap_l[255] !== 1'b1) $display("FAIL chroma_last255: got %0b want 1", cap_l[255]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ok0, ok1;
        int got, cyc, bad;
        rand_mcu(0);
        rand_mcu(1);
        write_mcu(1, 0, 256, ok0);
        n_total++; if (wr_ready !== 1'b1) $display("FAIL b2b_ready_after_256: got %0b want 1", wr_ready); else n_pass++;
        write_mcu(1, 1, 256, ok1);
        n_total++; if ((ok0 && ok1) !== 1'b1) $display("FAIL b2b_write: got %0b want 1", ok0 && ok1); else n_pass++;
        n_total++; if (wr_ready !== 1'b0) $display("FAIL b2b_ready_after_512: got %0b want 0", wr_ready); else n_pass++;
        wr_before = 1'bx;
        wr_after = 1'bx;
        drain(256, 0, got, cyc);
        n_total++; if (got !== 256) $display("FAIL b2b_count: got %0d want 256", got); else n_pass++;
        n_total++; if (cyc !== 256) $display("FAIL b2b_cycles: got %0d want 256", cyc); else n_pass++;
        n_total++; if (wr_before !== 1'b0) $display("FAIL b2b_ready_at_last: got %0b want 0", wr_before); else n_pass++;
        n_total++; if (wr_after !== 1'b1) $display("FAIL b2b_ready_after_last: got %0b want 1", wr_after); else n_pass++;
        bad = count_bad(1, 0, 0, 128) + count_bad(1, 1, 128, 128);
        n_total++; if (bad !== 0) $display("FAIL b2b_pixels: got %0d bad want 0", bad); else n_pass++;
    endtask

    task automatic test_stall;
        bit ok;
        int got, cyc, bad, n;
        for (int m = 0; m < 3; m++) begin
            n = (m == 0) ? 64 : (m == 1) ? 128 : 256;
            rand_mcu(0);
            write_mcu(m, 0, 384, ok);
            stall_bad = 0;
            drain(n, 1, got, cyc);
            n_total++; if (got !== n) $display("FAIL stall_count_m%0d: got %0d want %0d", m, got, n); else n_pass++;
            bad = count_bad(m, 0, 0, n);
            n_total++; if (bad !== 0) $display("FAIL stall_pixels_m%0d: got %0d bad want 0", m, bad); else n_pass++;
            n_total++; if (stall_bad !== 0) $display("FAIL stall_hold_m%0d: got %0d changes want 0", m, stall_bad); else n_pass++;
        end
    endtask

    task automatic test_illegal;
        bit ok, o;
        int got, cyc, bad;
        rand_mcu(0);
        mode = 2'd0;
        write_one(3'd2, 6'd5, 9'h1aa, o);
        wr_valid = 1'b0;
        n_total++; if (err !== 1'b1) $display("FAIL illegal_err: got %0b want 1", err); else n_pass++;
        write_one(3'd6, 6'd7, 9'h0f0, o);
        wr_valid = 1'b0;
        write_mcu(0, 0, 191, ok);
        repeat (4) tick;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL illegal_not_full_191: got %0b want 0", rd_valid); else n_pass++;
        write_one(3'd5, 6'd63, mCr[0][63], o);
        ok &= o;
        wr_valid = 1'b0;
        tick;
        tick;
        n_total++; if (rd_valid !== 1'b1) $display("FAIL illegal_full_192: got %0b want 1", rd_valid); else n_pass++;
        drain(64, 0, got, cyc);
        bad = count_bad(0, 0, 0, 64) + (got == 64 ? 0 : 1) + (ok ? 0 : 1);
        n_total++; if (bad !== 0) $display("FAIL illegal_pixels: got %0d bad want 0", bad); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL illegal_err_sticky: got %0b want 1", err); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int got, cyc, bad;
        rand_mcu(0);
        write_mcu(2, 0, 384, ok);
        drain(30, 0, got, cyc);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid: got %0b want 0", rd_valid); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL midrst_wr_ready: got %0b want 1", wr_ready); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL midrst_err: got %0b want 0", err); else n_pass++;
        rand_mcu(0);
        write_mcu(0, 0, 192, ok);
        drain(64, 0, got, cyc);
        n_total++; if (got !== 64) $display("FAIL midrst_count: got %0d want 64", got); else n_pass++;
        bad = count_bad(0, 0, 0, 64);
        n_total++; if (bad !== 0) $display("FAIL midrst_pixels: got %0d bad want 0", bad); else n_pass++;
        n_total++; if (cap_f[0] !== 1'b1) $display("FAIL midrst_first: got %0b want 1", cap_f[0]); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        stall_bad = 0;
        rst = 1'b1;
        mode = 2'd0;
        wr_valid = 1'b0;
        wr_color = 3'd0;
        wr_addr = 6'd0;
        wr_data = 9'd0;
        rd_ready = 1'b0;
        wr_before = 1'b0;
        wr_after = 1'b0;
        test_reset;
        test_ramp;
        test_chroma;
        test_back_to_back;
        test_stall;
        test_illegal;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
